// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a shared N:1 mux tree: grants one requester at a time,
// bounds each ownership at MAX_HOLD cycles and inserts one dead cycle between owners.
module mux_arbiter #(
  parameter int N        = 4,
  parameter int SELW     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            timeout
);

  localparam int CW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] ptr;
  logic            any_req;
  logic [SELW-1:0] win;
  logic            rel_norm;
  logic            rel_lim;
  logic [SELW-1:0] ptr_next;

  // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        win     = SELW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        win = SELW'(i);
      end
    end
  end

  assign rel_norm = done | ~req[sel];
  assign rel_lim  = (cnt == CW'(MAX_HOLD - 1));
  assign ptr_next = (sel == SELW'(N - 1)) ? '0 : sel + 1'b1;

  // A limit release coinciding with done or a req drop is reported as a normal release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      ptr     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state <= OWN;
            gnt   <= {{(N-1){1'b0}}, 1'b1} << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (rel_norm || rel_lim) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= ptr_next;
            timeout <= rel_lim & ~rel_norm;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed testbench for mux_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_mux_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int checks;
  int errors;

  mux_arbiter #(.N(4), .SELW(2), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    done    = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    done    = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rst_gnt: got %b expected 0000", gnt); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL rst_sel: got %0d expected 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout: got %b expected 0", timeout); end
    reset_n = 1'b1;
    req     = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL first_gnt: got %b expected 0001", gnt); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL first_sel: got %0d expected 0", sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy: got %b expected 1", busy); end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL done_gap_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_gap_busy: got %b expected 0", busy); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL idle_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_gnt = 4'b0001 << k;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("[TB] FAIL rot_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
      checks++; if (sel !== 2'(k)) begin errors++; $display("[TB] FAIL rot_sel[%0d]: got %0d expected %0d", k, sel, k); end
      tick();
      checks++; if (gnt !== exp_gnt) begin errors++; $display("[TB] FAIL rot_hold[%0d]: got %b expected %b", k, gnt, exp_gnt); end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rot_gap[%0d]: got %b expected 0000", k, gnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL rot_timeout[%0d]: got %b expected 0", k, timeout); end
      checks++; if (sel !== 2'(k)) begin errors++; $display("[TB] FAIL rot_gap_sel[%0d]: got %0d expected %0d", k, sel, k); end
      tick();
    end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rot_wrap: got %b expected 0001", gnt); end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0100;
    tick();
    for (int c = 0; c < 8; c++) begin
      checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL hold_gnt[%0d]: got %b expected 0100", c, gnt); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL hold_timeout[%0d]: got %b expected 0", c, timeout); end
      tick();
    end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL limit_gnt: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL limit_timeout: got %b expected 1", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL limit_busy: got %b expected 0", busy); end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL regrant_gnt: got %b expected 0100", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL regrant_timeout: got %b expected 0", timeout); end
    req = 4'b0000;
  endtask

  task automatic test_limit_with_done();
    do_reset();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL own1_gnt: got %b expected 0010", gnt); end
    repeat (7) tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL own1_last_gnt: got %b expected 0010", gnt); end
    done = 1'b1;
    req  = 4'b0111;
    tick();
    done = 1'b0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL limdone_gap_gnt: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL limdone_timeout: got %b expected 0", timeout); end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL limdone_next_gnt: got %b expected 0100", gnt); end
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL limdone_next_sel: got %0d expected 2", sel); end
    req = 4'b0000;
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b1011;
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL drop_pre_sel: got %0d expected 2", sel); end
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL drop_pre_gnt: got %b expected 0100", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL drop_gap_gnt: got %b expected 0000", gnt); end
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL drop_gap_sel: got %0d expected 2", sel); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL drop_timeout: got %b expected 0", timeout); end
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL drop_next_gnt: got %b expected 1000", gnt); end
    checks++; if (sel !== 2'd3) begin errors++; $display("[TB] FAIL drop_next_sel: got %0d expected 3", sel); end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL ar_own_gnt: got %b expected 0100", gnt); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL ar_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_busy: got %b expected 0", busy); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL ar_sel: got %0d expected 0", sel); end
    req = 4'b0010;
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL ar_after_gnt: got %b expected 0010", gnt); end
    checks++; if (sel !== 2'd1) begin errors++; $display("[TB] FAIL ar_after_sel: got %0d expected 1", sel); end
    req = 4'b0000;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    req     = 4'b0000;
    done    = 1'b0;
    test_reset();
    test_rotation();
    test_timeout();
    test_limit_with_done();
    test_req_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared N:1 output path built as a tree of 2:1 muxes.
- Accepts up to N requesters and grants the path to one at a time.
- Drives the binary mux select and a one-hot grant, holding ownership until the owner releases or a hold limit expires.
- Inserts one dead cycle between owners so the mux select never changes while a grant is active.

Parameters:
- N, 4, number of requesters (2..8).
- SELW, 2, width of sel; must equal clog2(N).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the path (2..256).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; level-sensitive.
- done  input  1  owner signals last transfer this cycle; ignored unless state is OWN.
- gnt  output  N  one-hot grant, registered; all zero when nobody owns the path.
- sel  output  SELW  binary index of current/last owner, registered; drives the mux tree.
- busy  output  1  high while state is OWN.
- timeout  output  1  one-cycle pulse when ownership is forcibly revoked at MAX_HOLD.

Behaviour:
- Reset (reset_n low, async):
  - gnt=0, sel=0, busy=0, timeout=0.
  - State IDLE, hold counter=0, priority pointer ptr=0.
  - Reset during OWN clears gnt immediately, without waiting for clk.
- State IDLE:
  - gnt=0.
  - If req!=0, pick the first set bit searching ptr, ptr+1, ... wrapping mod N.
  - Next edge: gnt=onehot(winner), sel=winner, busy=1, counter=0, go to OWN.
  - If req==0, stay in IDLE; sel keeps its last value.
- State OWN:
  - gnt, sel and busy are held stable; counter increments each cycle.
  - Release condition (any one suffices):
    - done=1;
    - req[sel]=0;
    - counter==MAX_HOLD-1, i.e. the MAX_HOLD-th cycle of ownership.
  - On release, the next edge gives gnt=0, busy=0, ptr=(sel+1) mod N, and moves to GAP.
  - timeout=1 for the GAP cycle only when the release came solely from the counter limit.
  - done or a req drop in the same cycle as the limit counts as a normal release (timeout=0).
- State GAP (exactly 1 cycle):
  - gnt=0; sel unchanged.
  - Arbitration is evaluated exactly as in IDLE using the updated ptr.
  - If any req, the next edge enters OWN with a new winner; otherwise go to IDLE.
  - The releasing owner may win again only if no other req bit is set.
- Latency:
  - Request to grant: 1 cycle from IDLE.
  - Release to next grant: 2 edges (OWN→GAP→OWN).
- Fairness: with all requesters continuously asserting, grants rotate 0,1,...,N-1,0.
- sel changes only on the edge that enters OWN, never while gnt!=0.
- Requests that appear or drop in IDLE/GAP are sampled only at that edge; no grant is given for a req that was low at the sampling edge.
- An out-of-range index (N not a power of 2) is never produced.

Test Plan:
- Reset release with req=0001 → cycle 1: gnt=0001, sel=0, busy=1; done pulse → next cycle gnt=0, then IDLE.
- req=1111 held, done pulsed on the 3rd cycle of each ownership → grant sequence 0001,0010,0100,1000,0001; gnt=0 for one cycle between each; timeout never set.
- req=0100 held, done never asserted, MAX_HOLD=8 → gnt=0100 for exactly 8 cycles, then timeout=1 with gnt=0 for one cycle, then gnt=0100 again (sole requester).
- In OWN with owner 1: done=1 on the same cycle counter reaches 7 → release with timeout=0; ptr=2, so with req=0111 the next grant is 0100.
- Owner 2 drops req mid-hold with req=1011 → one GAP cycle, then gnt=1000, sel=3; sel did not change while gnt was nonzero.
- Assert reset_n=0 asynchronously mid-OWN (between clock edges) → gnt, busy and sel read 0 before the next edge; after release with req=0010 → gnt=0010 (ptr restarted at 0).
